blink_sequencer: RTL

BLINK_SEQUENCER -- requirements
Module: blink_sequencer

---
 rtl/blink_sequencer.sv | 121 ++++++++++++
 1 files changed

// File: rtl/blink_sequencer.sv
// LED pattern sequencer: accepts one command at a time and steps a pattern
// (toggle, walking-one, binary count) every `period` clocks for `repeat` steps.
module blink_sequencer #(
    parameter int OUTPUT_WIDTH = 4,
    parameter int PERIOD_WIDTH = 24
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [1:0]              cmd_mode,
    input  logic [PERIOD_WIDTH-1:0] cmd_period,
    input  logic [7:0]              cmd_repeat,
    input  logic                    abort,
    output logic [OUTPUT_WIDTH-1:0] out,
    output logic                    busy,
    output logic                    done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] MODE_OFF    = 2'd0;
    localparam logic [1:0] MODE_TOGGLE = 2'd1;
    localparam logic [1:0] MODE_WALK   = 2'd2;
    localparam logic [1:0] MODE_COUNT  = 2'd3;

    state_t                  state;
    logic [1:0]              mode_q;
    logic [PERIOD_WIDTH-1:0] period_q;
    logic [7:0]              repeat_q;
    logic [PERIOD_WIDTH-1:0] prescaler;
    logic [7:0]              step_cnt;

    logic [PERIOD_WIDTH-1:0] period_last;
    logic [OUTPUT_WIDTH-1:0] init_out;
    logic [OUTPUT_WIDTH-1:0] next_out;
    logic                    step_now;
    logic                    last_step;

    assign cmd_ready = (state == IDLE) && !abort;
    // busy/done are masked by rst so they read 0 for the whole reset cycle.
    assign busy      = (state != IDLE) && !rst;
    assign done      = (state == DONE) && !rst;

    // A latched period of 0 behaves exactly like a period of 1.
    assign period_last = (period_q == '0) ? '0 : period_q - PERIOD_WIDTH'(1);
    assign step_now    = (prescaler == period_last);
    assign last_step   = (repeat_q != 8'd0) && ((step_cnt + 8'd1) == repeat_q);

    always_comb begin
        init_out = '0;
        case (cmd_mode)
            MODE_TOGGLE: init_out = '1;
            MODE_WALK:   init_out = OUTPUT_WIDTH'(1);
            default:     init_out = '0;
        endcase
    end

    always_comb begin
        next_out = out;
        case (mode_q)
            MODE_TOGGLE: next_out = ~out;
            MODE_WALK:   next_out = {out[OUTPUT_WIDTH-2:0], out[OUTPUT_WIDTH-1]};
            MODE_COUNT:  next_out = out + OUTPUT_WIDTH'(1);
            default:     next_out = out;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            out       <= '0;
            prescaler <= '0;
            step_cnt  <= '0;
            mode_q    <= '0;
            period_q  <= '0;
            repeat_q  <= '0;
        end else if (abort) begin
            state     <= IDLE;
            out       <= '0;
            prescaler <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        mode_q    <= cmd_mode;
                        period_q  <= cmd_period;
                        repeat_q  <= cmd_repeat;
                        prescaler <= '0;
                        step_cnt  <= '0;
                        out       <= init_out;
                        state     <= (cmd_mode == MODE_OFF) ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (step_now) begin
                        prescaler <= '0;
                        step_cnt  <= step_cnt + 8'd1;
                        out       <= next_out;
                        if (last_step) begin
                            state <= DONE;
                        end
                    end else begin
                        prescaler <= prescaler + PERIOD_WIDTH'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
